rand_pixel_sampler: RTL

- Consumes the 12-bit pseudo-random word stream from the LFSR random generator and turns it into random on-screen pixel writes (x, y, colour).
- Writes are sent to the framebuffer/draw arbiter over a valid/ready handshake.
- Uses rejection sampling so that coordinates are uniform over the active area.
- Used by the GPU's "noise/starfield" draw command; a run of N pixels is triggered by a start pulse.

---
 rtl/rand_pixel_sampler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/rand_pixel_sampler.sv
// -----------------------------------------------------------------------------
// rand_pixel_sampler
//
// Purpose:
//   Turns the 12-bit pseudo-random word stream from the LFSR generator into
//   random pixel writes (x, y, colour) for the "noise/starfield" draw command.
//   Coordinates are drawn by rejection sampling so they are uniform over the
//   active area. A start pulse launches a run of num_pix pixels, and each pixel
//   is offered downstream over a valid/ready handshake.
//
// Handshake:
//   A pixel transfers on every rising clk edge where pix_valid && pix_ready.
//   Once pix_valid is high, it stays high and pix_x/pix_y/pix_color stay
//   stable until that transfer. pix_ready is ignored outside EMIT.
//
// Ports:
//   clk        in   1        system clock
//   reset_n    in   1        asynchronous active-low reset
//   rand_num   in   12       random word, new value every cycle
//   start      in   1        single-cycle command pulse (ignored while busy)
//   num_pix    in   16       pixel count for the run, sampled on start
//   pix_valid  out  1        pixel write request
//   pix_ready  in   1        downstream accepts the pixel
//   pix_x      out  10       pixel x coordinate
//   pix_y      out  9        pixel y coordinate
//   pix_color  out  COLOR_W  pixel colour
//   busy       out  1        high from the start edge until the run ends
//   done       out  1        one-cycle pulse when the run ends
//   reject_cnt out  16       saturating count of rejected coordinate samples
//                            (only present when RAND_REJECT_CNT_EN is defined)
//   dbg_state  out  3        current FSM state encoding (for observation)
//
// Configuration macro:
//   RAND_REJECT_CNT_EN - adds the reject_cnt output and its counter.
//
// Parameters:
//   H_ACTIVE (<= 1024), V_ACTIVE (<= 512), COLOR_W (1..12).
// -----------------------------------------------------------------------------
module rand_pixel_sampler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [11:0]        rand_num,
    input  logic               start,
    input  logic [15:0]        num_pix,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [9:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done,
`ifdef RAND_REJECT_CNT_EN
    output logic [15:0]        reject_cnt,
`endif
    output logic [2:0]         dbg_state
);

    // One bit wider than the sampled field so that H_ACTIVE = 1024 and
    // V_ACTIVE = 512 (accept every value) can still be represented.
    localparam logic [10:0] LP_H_ACTIVE = 11'(H_ACTIVE);
    localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLE_X = 3'd1,
        ST_SAMPLE_Y = 3'd2,
        ST_SAMPLE_C = 3'd3,
        ST_EMIT     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [15:0]         r_remaining;
    logic                r_pix_valid;
    logic [9:0]          r_pix_x;
    logic [8:0]          r_pix_y;
    logic [COLOR_W-1:0]  r_pix_color;
    logic                r_busy;
    logic                r_done;

    logic                w_x_ok;
    logic                w_y_ok;
    logic                w_start_run;
    logic                w_start_zero;
    logic                w_handshake;
    logic                w_last;

    // rand_num[11:10] never feed a coordinate field and only feed the colour
    // when COLOR_W > 10; this reduction keeps them formally consumed.
    logic                w_unused_bits;
    assign w_unused_bits = ^rand_num[11:10];

    // Unsigned compares of the low rand_num bits; upper bits are ignored.
    assign w_x_ok       = ({1'b0, rand_num[9:0]} < LP_H_ACTIVE);
    assign w_y_ok       = ({1'b0, rand_num[8:0]} < LP_V_ACTIVE);

    // start only matters in IDLE; a pulse while busy is dropped entirely.
    assign w_start_run  = (r_state == ST_IDLE) && start && (num_pix != 16'd0);
    assign w_start_zero = (r_state == ST_IDLE) && start && (num_pix == 16'd0);

    assign w_handshake  = (r_state == ST_EMIT) && r_pix_valid && pix_ready;
    assign w_last       = (r_remaining == 16'd1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_run) begin
                    w_next_state = ST_SAMPLE_X;
                end
            end
            ST_SAMPLE_X: begin
                if (w_x_ok) begin
                    w_next_state = ST_SAMPLE_Y;
                end
            end
            ST_SAMPLE_Y: begin
                if (w_y_ok) begin
                    w_next_state = ST_SAMPLE_C;
                end
            end
            ST_SAMPLE_C: begin
                w_next_state = ST_EMIT;
            end
            ST_EMIT: begin
                if (w_handshake) begin
                    w_next_state = w_last ? ST_IDLE : ST_SAMPLE_X;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= 16'd0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 9'd0;
            r_pix_color <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a pulse: it is low unless this edge ends a run.
            r_done <= 1'b0;

            if (w_start_zero) begin
                // Empty run completes immediately without ever going busy.
                r_done <= 1'b1;
            end

            if (w_start_run) begin
                r_remaining <= num_pix;
                r_busy      <= 1'b1;
            end

            if ((r_state == ST_SAMPLE_X) && w_x_ok) begin
                r_pix_x <= rand_num[9:0];
            end

            if ((r_state == ST_SAMPLE_Y) && w_y_ok) begin
                r_pix_y <= rand_num[8:0];
            end

            if (r_state == ST_SAMPLE_C) begin
                r_pix_color <= rand_num[COLOR_W-1:0];
                r_pix_valid <= 1'b1;
            end

            if (w_handshake) begin
                r_pix_valid <= 1'b0;
                if (w_last) begin
                    r_remaining <= 16'd0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                end else begin
                    r_remaining <= r_remaining - 16'd1;
                end
            end
        end
    end

`ifdef RAND_REJECT_CNT_EN
    // ------------------------------------------------------------------
    // Reject counter: counts coordinate rejections of the current run,
    // saturating, and holds after done until the next start.
    // ------------------------------------------------------------------
    logic [15:0] r_reject_cnt;
    logic        w_reject;

    assign w_reject = ((r_state == ST_SAMPLE_X) && !w_x_ok) ||
                      ((r_state == ST_SAMPLE_Y) && !w_y_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reject_cnt <= 16'd0;
        end else if (w_start_run || w_start_zero) begin
            r_reject_cnt <= 16'd0;
        end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end

    assign reject_cnt = r_reject_cnt;
`endif

    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_color = r_pix_color;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
